// File: rtl/sram_result_drain.sv
`default_nettype none
// ============================================================================
// Module      : sram_result_drain
// Description : Credit-based result SRAM reader feeding a valid/ready stream.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_result_drain #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start_valid,
    output logic                  start_ready,
    input  logic [ADDR_WIDTH-1:0] start_base_addr,
    input  logic [15:0]           start_count,
    output logic [ADDR_WIDTH-1:0] dut__tb__sram_result_read_address,
    input  logic [DATA_WIDTH-1:0] tb__dut__sram_result_read_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  done
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [15:0]           r_remaining;
    logic                  r_pend_a;
    logic                  r_last_a;
    logic                  r_pend_d;
    logic                  r_last_d;
    logic                  r_done;
    logic [DATA_WIDTH-1:0] r_mem_data [FIFO_DEPTH];
    logic                  r_mem_last [FIFO_DEPTH];
    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_entries;

    logic                  w_handshake;
    logic [1:0]            w_outstanding;
    logic [CW:0]           w_used;
    logic                  w_credit;
    logic                  w_issue;
    logic                  w_issue_first;
    logic                  w_issue_last;
    logic                  w_done_next;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_head_last;

    // A read is in flight for two cycles: address stage, then data stage.
    assign w_handshake   = start_valid && (r_state == S_IDLE);
    assign w_outstanding = {1'b0, r_pend_a} + {1'b0, r_pend_d};
    assign w_used        = (CW+1)'(r_entries) + (CW+1)'(w_outstanding);
    assign w_credit      = w_used < (CW+1)'(FIFO_DEPTH);
    assign w_push        = r_pend_d;
    assign w_pop         = out_valid && out_ready;
    assign w_head_last   = r_mem_last[r_rd_ptr];

    always_comb begin
        w_state_next  = r_state;
        w_issue       = 1'b0;
        w_issue_first = 1'b0;
        w_issue_last  = 1'b0;
        w_done_next   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_handshake) begin
                    if (start_count == 16'd0) begin
                        w_done_next = 1'b1;
                    end else begin
                        w_issue       = 1'b1;
                        w_issue_first = 1'b1;
                        w_issue_last  = (start_count == 16'd1);
                        w_state_next  = w_issue_last ? S_DRAIN : S_READ;
                    end
                end
            end
            S_READ: begin
                if (w_credit && (r_remaining != 16'd0)) begin
                    w_issue      = 1'b1;
                    w_issue_last = (r_remaining == 16'd1);
                    if (w_issue_last) begin
                        w_state_next = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (w_pop && w_head_last) begin
                    w_state_next = S_IDLE;
                    w_done_next  = 1'b1;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_remaining <= '0;
            r_pend_a    <= 1'b0;
            r_last_a    <= 1'b0;
            r_pend_d    <= 1'b0;
            r_last_d    <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_done   <= w_done_next;
            r_pend_a <= w_issue;
            r_last_a <= w_issue_last;
            r_pend_d <= r_pend_a;
            r_last_d <= r_last_a;
            if (w_issue) begin
                r_addr <= w_issue_first ? start_base_addr : r_addr + ADDR_WIDTH'(1);
            end
            if (w_issue_first) begin
                r_remaining <= start_count - 16'd1;
            end else if (w_issue) begin
                r_remaining <= r_remaining - 16'd1;
            end
        end
    end

    // Output FIFO; the head entry drives the stream directly (no bypass).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem_data[i] <= '0;
                r_mem_last[i] <= 1'b0;
            end
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_entries <= '0;
        end else begin
            if (w_push) begin
                r_mem_data[r_wr_ptr] <= tb__dut__sram_result_read_data;
                r_mem_last[r_wr_ptr] <= r_last_d;
                r_wr_ptr             <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_entries <= r_entries + CW'(1);
                2'b01:   r_entries <= r_entries - CW'(1);
                default: r_entries <= r_entries;
            endcase
        end
    end

    assign start_ready                       = (r_state == S_IDLE);
    assign dut__tb__sram_result_read_address = r_addr;
    assign out_valid                         = (r_entries != '0);
    assign out_data                          = r_mem_data[r_rd_ptr];
    assign out_last                          = out_valid && w_head_last;
    assign done                              = r_done;

endmodule
`default_nettype wire

// File: doc/sram_result_drain.md
Name: sram_result_drain

Overview:
Reads a block of result words out of the result SRAM, after the matrix-multiply engine has written them, and presents them as a valid/ready stream. It is the read side of the result SRAM interface that the engine writes: the engine drives write address, data and enable; this block drives the read address and consumes the read data. A command handshake supplies the base address and word count. Output backpressure is absorbed by a small FIFO, and SRAM reads are issued on a credit basis, so no returned word is ever dropped.

Parameters:
ADDR_WIDTH, 16, SRAM address width; matches `SRAM_ADDR_RANGE.
DATA_WIDTH, 32, SRAM word width; matches `SRAM_DATA_RANGE.
FIFO_DEPTH, 4, output buffer entries; power of two, minimum 2.

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
start_valid  in  1  command request
start_ready  out  1  high when idle and able to accept a command
start_base_addr  in  ADDR_WIDTH  first SRAM address to read (the engine's first result is at address 1)
start_count  in  16  number of words to read
dut__tb__sram_result_read_address  out  ADDR_WIDTH  registered SRAM read address
tb__dut__sram_result_read_data  in  DATA_WIDTH  SRAM read data, valid one cycle after the address
out_valid  out  1  stream word available
out_ready  in  1  downstream accepts the word
out_data  out  DATA_WIDTH  stream word
out_last  out  1  high with the final word of a command
done  out  1  one-cycle pulse when a command completes

Behaviour:
- Reset, asynchronous, active-low:
  - start_ready=1, read_address=0, out_valid=0, out_data=0, out_last=0, done=0.
  - FIFO empty, outstanding=0, state IDLE.
  - In-flight reads are discarded. A reset in the middle of a command aborts it with no done pulse.
- States: IDLE, READ, DRAIN.
- IDLE:
  - start_ready=1.
  - start_valid&start_ready in cycle T latches base, count and remaining=count.
  - If count!=0, go to READ. If count==0, go to IDLE, pulse done in T+1, and emit no words.
- Command handshake: start_valid while busy is ignored (start_ready=0). Command inputs are sampled only at the handshake.
- READ, one issue per cycle at most:
  - Issue when entries+outstanding < FIFO_DEPTH and issued < count.
  - entries is the FIFO occupancy at the start of the cycle; outstanding is reads issued but not yet captured.
  - Issue loads read_address (the first issue loads base, later issues load address+1) and sets the capture flag for the next cycle.
  - Address arithmetic is modulo 2^ADDR_WIDTH: 0xFFFF+1 wraps to 0x0000.
  - When not issuing, the address holds its value and the SRAM data in the following cycle is ignored.
- Capture: in the cycle after an issue, tb__dut__sram_result_read_data is written into the FIFO at the clock edge.
- Transition: after the last issue, go to DRAIN.
- DRAIN: wait until the FIFO is empty and outstanding=0.
- Output stream:
  - out_valid = FIFO not empty; out_data and out_last come from the FIFO head, which is registered.
  - The word is popped on out_valid&out_ready.
  - out_data and out_valid hold stable while out_valid=1 and out_ready=0.
  - out_last is tagged on the word from issue number count.
  - Push and pop in the same cycle are both legal, including when full (pop frees the slot) and when empty (no bypass; the word appears next cycle).
- Completion:
  - The cycle after the pop of the out_last word: done=1 for one cycle, start_ready=1, state IDLE.
  - A new command may be accepted in that same cycle.
- Latency: command accepted at T, first address driven at T+1, data captured at the end of T+2, out_valid=1 at T+3.
- Throughput: with out_ready held high and FIFO_DEPTH>=4, one word per cycle.
- Width: remaining and issued counters are 16-bit; count up to 65535 is supported.

Test Plan:
- Basic read: SRAM[1..4]=0x3F800000,0x40000000,0x40400000,0x40800000; start base=1, count=4, out_ready=1 -> four words appear in order on consecutive cycles starting at T+3. out_last is set on 0x40800000 only, done pulses at T+7, and the address sequence is 1,2,3,4.
- Backpressure: base=1, count=8, out_ready toggling 1,0,0,1,... and then low for 10 cycles -> all 8 words are delivered in order with none lost or duplicated. Issues stop while entries+outstanding=4, and out_data is stable while stalled.
- Zero count: start count=0 -> no out_valid, done one cycle after the handshake, and the address never changes.
- Address wrap: base=0xFFFE, count=4 -> addresses 0xFFFE,0xFFFF,0x0000,0x0001, and the data matches those locations.
- Busy/back-to-back: start_valid is held high during a command, then a second command with base=10, count=2 is accepted in the done cycle -> the busy assertion is ignored, and the second command's first word appears 3 cycles after acceptance.
- Reset mid-operation: assert reset_n=0 after 3 of 8 words -> all outputs return to their reset values immediately. After release, a fresh command with count=2 yields exactly 2 words and no stale data.
